tone_fx_engine: RTL and testbench
=================================

TONE_FX_ENGINE -- requirements
Module: tone_fx_engine

Interface
REQ-001 Parameters SHALL be:
- PER_W, 16, width of the tone period counter and measured period.
- OCT_W, 2, width of oct_steps; the maximum octave-down shift is 2^OCT_W-1.
- TREM_W, 16, width of trem_rate.
- LED_DIV, 64, tone rising edges per LED beat cycle (at least 2).
REQ-002 Ports SHALL be:
- clk  input  1  system clock; the block uses one clock.
- rst_n  input  1  asynchronous, active-low reset.
- tone_in  input  1  square-wave tone, asynchronous to clk.
- oct_mode  input  2  00 bypass, 01 octave down, 10 octave up, 11 bypass.
- oct_steps  input  OCT_W  number of octaves down in mode 01.
- trem_ena  input  1  tremolo enable.
- trem_rate  input  TREM_W  tremolo gate half-period minus 1, in clk cycles.
- led_ena  input  1  LED beat enable.
- audio_out  output  1  processed tone, registered.
- led_out  output  1  beat indicator, registered.
- period_valid  output  1  the measured tone period is usable.

Function
REQ-003 tone_in SHALL pass through a 2-flop synchronizer (s1, s2) plus a delay flop s3; tone_rise = s2 & ~s3.
REQ-004 In bypass, audio_out SHALL equal tone_in delayed by exactly 3 clk cycles, before tremolo gating.
REQ-005 An octave-down counter of (2^OCT_W)-1 bits SHALL increment on every tone_rise and wrap to 0 at all-ones.
REQ-006 In mode 01, the shifted tone SHALL be counter bit [oct_steps-1]; oct_steps=0 SHALL select s2.
REQ-007 per_cnt SHALL load 1 on tone_rise and otherwise increment, saturating at all-ones.
REQ-008 On tone_rise, the register P SHALL load per_cnt, and period_valid SHALL set only if per_cnt is below all-ones and at least one earlier rise has occurred since reset.
REQ-009 When per_cnt reaches all-ones (tone stopped), period_valid SHALL clear on the next cycle and P SHALL hold its value.
REQ-010 Octave-up generator, active in mode 10:
- On tone_rise, up_q SHALL be set to 1 and up_cnt cleared.
- Otherwise up_cnt SHALL increment, and when up_cnt = (P>>2)-1, up_q SHALL toggle and up_cnt clear.
- The result is twice the input frequency, re-phased on every rise.
REQ-011 In mode 10, the shifted tone SHALL fall back to s2 while period_valid=0 or P<4.
REQ-012 Tremolo:
- trem_cnt SHALL count 0..trem_rate; at trem_rate, trem_cnt SHALL clear and trem_gate toggle.
- trem_gate SHALL be forced to 1 and trem_cnt held at 0 while trem_ena=0 or trem_rate=0.
REQ-013 audio_out SHALL be registered as (shifted tone AND trem_gate).
REQ-014 beat_cnt SHALL count tone_rise events modulo LED_DIV, running regardless of led_ena.
REQ-015 led_out SHALL be registered as led_ena AND (beat_cnt != 0), giving one dark beat per LED_DIV rises.
REQ-016 Changes to oct_mode, oct_steps or trem_rate SHALL take effect on the next clk edge without clearing any counter.
REQ-017 A trem_rate change below the current trem_cnt SHALL cause trem_cnt to wrap through all-ones before the gate toggles again; this behaviour is accepted and not a defect.
REQ-018 All counters SHALL wrap or saturate only as stated above; no arithmetic SHALL exceed its declared width.

Reset
REQ-019 While rst_n=0, all flops SHALL clear asynchronously to 0, except trem_gate, which SHALL be set to 1.
REQ-020 During reset, audio_out=0, led_out=0 and period_valid=0.
REQ-021 Reset asserted mid-operation SHALL discard P; period_valid SHALL require two new rises after release.
REQ-022 After rst_n deasserts, the block SHALL resume operation on the first clk edge.

Verification
REQ-023 Bypass: tone period 40 clk, trem_ena=0 -> audio_out matches tone_in with a 3-cycle lag.
REQ-024 Down: oct_mode=01, oct_steps=2, tone period 40 -> audio_out period 160 with 50% duty; oct_steps=0 -> behaves as bypass.
REQ-025 Up: oct_mode=10, tone period 40 -> period_valid=1 after the 2nd rise, then audio_out toggles every 10 cycles (period 20).
REQ-026 Stop: tone_in held low for 2^PER_W cycles -> period_valid falls and audio_out follows s2 (low).
REQ-027 Tremolo: trem_ena=1, trem_rate=99, tone period 40 -> audio_out gated off in alternate 100-cycle windows; trem_rate=0 -> no gating.
REQ-028 LED and reset: LED_DIV=64, led_ena=1, 130 rises -> led_out low for exactly two beat intervals; rst_n pulsed low mid-run -> all outputs 0 immediately, period_valid returns only after 2 rises.

Source files
------------

// File: rtl/tone_fx_engine.sv
// Guitar-style tone effects: octave down/up, tremolo gate and a beat LED on a synchronized square wave.
// audio_out trails tone_in by three clk edges; free-running stream with no backpressure.
`timescale 1ns/1ps
module tone_fx_engine #(
  parameter int PER_W   = 16,
  parameter int OCT_W   = 2,
  parameter int TREM_W  = 16,
  parameter int LED_DIV = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tone_in,
  input  logic [1:0]        oct_mode,
  input  logic [OCT_W-1:0]  oct_steps,
  input  logic              trem_ena,
  input  logic [TREM_W-1:0] trem_rate,
  input  logic              led_ena,
  output logic              audio_out,
  output logic              led_out,
  output logic              period_valid
);

  localparam int DCNT_W = (1 << OCT_W) - 1;
  localparam int BEAT_W = $clog2(LED_DIV);

  localparam logic [PER_W-1:0]  PER_ONE  = PER_W'(1);
  localparam logic [PER_W-1:0]  PER_FOUR = PER_W'(4);
  localparam logic [DCNT_W-1:0] DCNT_ONE = DCNT_W'(1);
  localparam logic [TREM_W-1:0] TREM_ONE = TREM_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_TOP = BEAT_W'(LED_DIV - 1);
  localparam logic [OCT_W-1:0]  OCT_ONE  = OCT_W'(1);

  logic              s1_q, s2_q, s3_q;
  logic              tone_rise;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
  logic [PER_W-1:0]  per_q, per_d;
  logic              valid_q, valid_d;
  logic              seen_q, seen_d;
  logic [PER_W-1:0]  up_cnt_q, up_cnt_d;
  logic              up_q, up_d;
  logic [TREM_W-1:0] trem_cnt_q, trem_cnt_d;
  logic              gate_q, gate_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              audio_q, audio_d;
  logic              led_q, led_d;

  logic              per_sat;
  logic [PER_W-1:0]  up_last;
  logic [OCT_W-1:0]  sel_idx;
  logic              shifted;

  assign tone_rise = s2_q & ~s3_q;

  always_comb begin
    dcnt_d     = dcnt_q;
    per_cnt_d  = per_cnt_q;
    per_d      = per_q;
    valid_d    = valid_q;
    seen_d     = seen_q | tone_rise;
    up_cnt_d   = up_cnt_q;
    up_d       = up_q;
    trem_cnt_d = trem_cnt_q;
    gate_d     = gate_q;
    beat_d     = beat_q;
    per_sat    = (per_cnt_q == '1);
    up_last    = (per_q >> 2) - PER_ONE;
    sel_idx    = oct_steps - OCT_ONE;
    shifted    = s2_q;

    // A saturated per_cnt means the tone stopped; that interval is never a valid period.
    if (tone_rise) begin
      dcnt_d    = dcnt_q + DCNT_ONE;
      per_cnt_d = PER_ONE;
      per_d     = per_cnt_q;
      valid_d   = !per_sat && seen_q;
      beat_d    = (beat_q == BEAT_TOP) ? '0 : beat_q + BEAT_ONE;
    end else begin
      if (!per_sat) per_cnt_d = per_cnt_q + PER_ONE;
      else          valid_d   = 1'b0;
    end

    if (tone_rise) begin
      up_d     = 1'b1;
      up_cnt_d = '0;
    end else if (up_cnt_q == up_last) begin
      up_d     = ~up_q;
      up_cnt_d = '0;
    end else begin
      up_cnt_d = up_cnt_q + PER_ONE;
    end

    if (!trem_ena || trem_rate == '0) begin
      gate_d     = 1'b1;
      trem_cnt_d = '0;
    end else if (trem_cnt_q == trem_rate) begin
      gate_d     = ~gate_q;
      trem_cnt_d = '0;
    end else begin
      trem_cnt_d = trem_cnt_q + TREM_ONE;
    end

    case (oct_mode)
      2'b01:   shifted = (oct_steps == '0) ? s2_q : dcnt_q[sel_idx];
      2'b10:   shifted = (!valid_q || per_q < PER_FOUR) ? s2_q : up_q;
      default: shifted = s2_q;
    endcase

    audio_d = shifted & gate_q;
    led_d   = led_ena & (beat_q != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      dcnt_q     <= '0;
      per_cnt_q  <= '0;
      per_q      <= '0;
      valid_q    <= 1'b0;
      seen_q     <= 1'b0;
      up_cnt_q   <= '0;
      up_q       <= 1'b0;
      trem_cnt_q <= '0;
      gate_q     <= 1'b1;
      beat_q     <= '0;
      audio_q    <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      s1_q       <= tone_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      dcnt_q     <= dcnt_d;
      per_cnt_q  <= per_cnt_d;
      per_q      <= per_d;
      valid_q    <= valid_d;
      seen_q     <= seen_d;
      up_cnt_q   <= up_cnt_d;
      up_q       <= up_d;
      trem_cnt_q <= trem_cnt_d;
      gate_q     <= gate_d;
      beat_q     <= beat_d;
      audio_q    <= audio_d;
      led_q      <= led_d;
    end
  end

  assign audio_out    = audio_q;
  assign led_out      = led_q;
  assign period_valid = valid_q;

endmodule

// File: tb/tb_tone_fx_engine.sv
// Directed bench for tone_fx_engine: a 40-cycle square tone is driven just after each clk edge
// and audio/LED/period outputs are sampled 1 ns after the edge against hand-derived values.
`timescale 1ns/1ps
module tb_tone_fx_engine;

  localparam int PER_W   = 10;
  localparam int OCT_W   = 2;
  localparam int TREM_W  = 16;
  localparam int LED_DIV = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tone_in;
  logic [1:0]        oct_mode;
  logic [OCT_W-1:0]  oct_steps;
  logic              trem_ena;
  logic [TREM_W-1:0] trem_rate;
  logic              led_ena;
  logic              audio_out;
  logic              led_out;
  logic              period_valid;

  int         checks = 0;
  int         errors = 0;
  bit         tone_run = 1'b0;
  int         tone_ph = 0;
  int         tone_per = 40;
  int         rise_cnt = 0;
  logic [2:0] drv_hist = '0;

  tone_fx_engine #(
    .PER_W(PER_W), .OCT_W(OCT_W), .TREM_W(TREM_W), .LED_DIV(LED_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tone_in(tone_in), .oct_mode(oct_mode),
    .oct_steps(oct_steps), .trem_ena(trem_ena), .trem_rate(trem_rate),
    .led_ena(led_ena), .audio_out(audio_out), .led_out(led_out),
    .period_valid(period_valid)
  );

  always #5 clk = ~clk;

  // Tone source: low half first, then high; drv_hist[2] is the value driven three cycles back.
  initial begin : tone_gen
    logic v;
    tone_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (tone_run) begin
        v = (tone_ph >= tone_per / 2);
        tone_ph = (tone_ph + 1) % tone_per;
      end else begin
        v = 1'b0;
        tone_ph = 0;
      end
      if (v && !tone_in) rise_cnt++;
      tone_in = v;
      drv_hist = {drv_hist[1:0], v};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rises(input int n);
    int target;
    int budget;
    target = rise_cnt + n;
    budget = 0;
    while (rise_cnt < target && budget < 5000) begin
      tick(1);
      budget++;
    end
    check("rise_wait_timeout", 32'(rise_cnt >= target), 1);
    tick(4);
  endtask

  task automatic measure(input int n, output int hi, output int tr, output int maxlow,
                         output int lagerr);
    logic prev;
    int   lowrun;
    hi = 0; tr = 0; maxlow = 0; lagerr = 0; lowrun = 0;
    prev = audio_out;
    repeat (n) begin
      tick(1);
      if (audio_out === 1'b1) begin
        hi++;
        lowrun = 0;
      end else begin
        lowrun++;
        if (lowrun > maxlow) maxlow = lowrun;
      end
      if (audio_out !== prev) tr++;
      prev = audio_out;
      if (audio_out !== drv_hist[2]) lagerr++;
    end
  endtask

  initial begin : stim
    int hi, tr, maxlow, lagerr, budget, falls, lows;
    logic prev_led;

    rst_n = 1'b0; oct_mode = 2'b00; oct_steps = '0;
    trem_ena = 1'b0; trem_rate = '0; led_ena = 1'b0;
    tick(5);
    check("rst_audio", audio_out, 0);
    check("rst_led", led_out, 0);
    check("rst_valid", period_valid, 0);

    rst_n = 1'b1; led_ena = 1'b1; tone_run = 1'b1;
    tick(3);
    check("led_beat0_dark", led_out, 0);
    wait_rises(1);
    check("valid_after_1st_rise", period_valid, 0);
    wait_rises(1);
    check("valid_after_2nd_rise", period_valid, 1);
    check("led_lit_after_rise", led_out, 1);

    measure(200, hi, tr, maxlow, lagerr);
    check("bypass_lag3", lagerr, 0);
    check("bypass_transitions", tr, 10);
    check("bypass_high", hi, 100);

    oct_mode = 2'b01; oct_steps = 2'd2;
    tick(200);
    measure(320, hi, tr, maxlow, lagerr);
    check("down2_transitions", tr, 4);
    check("down2_high", hi, 160);

    oct_steps = 2'd0;
    tick(5);
    measure(200, hi, tr, maxlow, lagerr);
    check("down0_is_bypass", lagerr, 0);

    oct_mode = 2'b10;
    tick(50);
    measure(200, hi, tr, maxlow, lagerr);
    check("up_transitions", tr, 20);
    check("up_high", hi, 100);

    tone_run = 1'b0;
    tick(900);
    check("stop_valid_held", period_valid, 1);
    tick(200);
    check("stop_valid_cleared", period_valid, 0);
    check("stop_audio_low", audio_out, 0);

    tone_run = 1'b1;
    wait_rises(1);
    check("restart_valid_1st", period_valid, 0);
    wait_rises(1);
    check("restart_valid_2nd", period_valid, 1);

    oct_mode = 2'b00; trem_ena = 1'b1; trem_rate = 16'd99;
    tick(10);
    measure(400, hi, tr, maxlow, lagerr);
    check("trem_gap_100", 32'(maxlow >= 100 && maxlow <= 140), 1);
    check("trem_high_range", 32'(hi >= 80 && hi <= 120), 1);

    trem_rate = '0;
    tick(5);
    measure(200, hi, tr, maxlow, lagerr);
    check("trem_rate0_ungated", lagerr, 0);
    check("trem_rate0_high", hi, 100);

    budget = 0;
    while (audio_out !== 1'b1 && budget < 200) begin
      tick(1);
      budget++;
    end
    check("wait_audio_high", audio_out, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_audio", audio_out, 0);
    check("midrst_led", led_out, 0);
    check("midrst_valid", period_valid, 0);
    tone_run = 1'b0;
    @(posedge clk);
    tick(3);
    rst_n = 1'b1; tone_run = 1'b1;
    tick(3);
    check("postrst_led_dark", led_out, 0);
    wait_rises(1);
    check("postrst_valid_1st", period_valid, 0);
    wait_rises(1);
    check("postrst_valid_2nd", period_valid, 1);

    falls = 0; lows = 0; prev_led = led_out;
    repeat (5200) begin
      tick(1);
      if (led_out !== 1'b1) lows++;
      if (prev_led === 1'b1 && led_out !== 1'b1) falls++;
      prev_led = led_out;
    end
    check("led_dark_beats", falls, 2);
    check("led_dark_cycles", lows, 80);

    led_ena = 1'b0;
    tick(2);
    check("led_disabled", led_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
